// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM states, bundle stride helper and the
// bundle record for the default XLEN=32 / LANES=2 configuration.
package fetch_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int LANES_DEF = 2;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  function automatic int fetchStride(input int xlen, input int lanes);
    return (lanes * xlen) / 8;
  endfunction

  typedef struct packed {
    logic [LANES_DEF-1:0]          mask;
    logic [XLEN_DEF-1:0]           pc;
    logic [LANES_DEF*XLEN_DEF-1:0] data;
  } bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with occupancy count and a synchronous flush; the head
// entry is presented combinationally on data_o.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q;
  logic [AW-1:0]    wrPtr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop_i)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Storage carries no reset; consumers only look at it while non-empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Bundle fetch front end with in-order response tracking, redirect flush and
// halt. Define FETCH_UNALIGNED_EN to mask lanes below an unaligned redirect target.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              LANES    = 2,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [LANES*XLEN-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  halt,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [LANES*XLEN-1:0] dec_data,
  output logic [XLEN-1:0]       dec_pc,
  output logic [LANES-1:0]      dec_mask
);

  localparam int STRIDE = fetchStride(XLEN, LANES);
  localparam int DW     = LANES * XLEN;
  localparam int IW     = LANES + XLEN;
  localparam int BW     = LANES + XLEN + DW;
  localparam int CW     = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] OFFSET_MASK = XLEN'(STRIDE - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~OFFSET_MASK;

  fetchState_e     state_q;
  logic [XLEN-1:0] fetchPc_q;
  logic [LANES-1:0] nextMask_q;
  logic [CW-1:0]   discard_q;

  logic [LANES-1:0] redirectMask;
  logic [CW-1:0]   inflightCnt;
  logic [CW-1:0]   bundleCnt;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     inUse;
  logic            accept;
  logic            respKeep;
  logic            decPop;
  logic            inflightEmpty;
  logic            bundleEmpty;
  logic [IW-1:0]   inflightHead;
  logic [BW-1:0]   bundleHead;

  // Outstanding counts every request not yet answered, including ones to be discarded.
  assign outstanding = discard_q + inflightCnt;
  assign inUse       = {1'b0, outstanding} + {1'b0, bundleCnt};
  assign imem_req    = !reset && (state_q == FETCH) && !redirect &&
                       (inUse < (CW+1)'(QDEPTH));
  assign imem_addr   = fetchPc_q;
  assign accept      = imem_req && imem_gnt;
  assign respKeep    = imem_rvalid && !redirect && (discard_q == '0) && !inflightEmpty;

  assign dec_valid = !bundleEmpty;
  assign decPop    = dec_valid && dec_ready;
  assign dec_data  = dec_valid ? bundleHead[DW-1:0]            : '0;
  assign dec_pc    = dec_valid ? bundleHead[DW +: XLEN]        : '0;
  assign dec_mask  = dec_valid ? bundleHead[DW+XLEN +: LANES]  : '0;

`ifdef FETCH_UNALIGNED_EN
  logic [XLEN-1:0] startLane;
  assign startLane = (redirect_pc & OFFSET_MASK) >> $clog2(XLEN / 8);

  always_comb begin
    redirectMask = '0;
    for (int i = 0; i < LANES; i++) redirectMask[i] = (XLEN'(i) >= startLane);
  end
`else
  assign redirectMask = '1;
`endif

  fetch_fifo #(.WIDTH(IW), .DEPTH(QDEPTH)) inflightFifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (accept),
    .data_i  ({nextMask_q, fetchPc_q}),
    .pop_i   (respKeep),
    .data_o  (inflightHead),
    .empty_o (inflightEmpty),
    .count_o (inflightCnt)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(QDEPTH)) bundleFifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (respKeep),
    .data_i  ({inflightHead, imem_rdata}),
    .pop_i   (decPop),
    .data_o  (bundleHead),
    .empty_o (bundleEmpty),
    .count_o (bundleCnt)
  );

  // A response returning in the redirect cycle is dropped, so it leaves the discard count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetchPc_q  <= RESET_PC;
      nextMask_q <= '1;
      discard_q  <= '0;
    end else begin
      case (state_q)
        BOOT:    state_q <= FETCH;
        FETCH:   if (halt && !redirect) state_q <= HALTED;
        HALTED:  if (redirect) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
      if (redirect) begin
        fetchPc_q  <= redirect_pc & ALIGN_MASK;
        nextMask_q <= redirectMask;
        discard_q  <= outstanding - CW'(imem_rvalid && (outstanding != '0));
      end else begin
        if (accept) begin
          fetchPc_q  <= fetchPc_q + XLEN'(STRIDE);
          nextMask_q <= '1;
        end
        if (imem_rvalid && (discard_q != '0)) discard_q <= discard_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against an epoch-based reference model of the fetch front end.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN   = 32;
  localparam int LANES  = 2;
  localparam int QDEPTH = 4;
  localparam int STRIDE = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [63:0] dec_data;
  logic [31:0] dec_pc;
  logic [1:0]  dec_mask;

  fetch_unit #(.XLEN(XLEN), .LANES(LANES), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_data    (dec_data),
    .dec_pc      (dec_pc),
    .dec_mask    (dec_mask)
  );

  always #5 clk = ~clk;

  // A request travelling through the memory: which redirect epoch issued it decides
  // whether its response may reach the decoder.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    logic [1:0]  mask;
    logic [63:0] data;
    int          due;
  } memReq_t;

  memReq_t     pend[$];
  bundle_t     bq[$];
  fetchState_e mState = BOOT;
  logic [31:0] mPc = RESET_PC;
  logic [1:0]  mMask = 2'b11;
  bit          mReq;
  int          epoch = 0;
  int          cycle = 0;
  bit          started = 0;

  int  gntPct = 100, readyPct = 100, latMin = 1, latMax = 1;
  bit  kRedirect = 0, kHalt = 0;
  logic [31:0] kRedirectPc = '0;

  logic        sReq, sValid;
  logic [31:0] sAddr, sPc;
  logic [1:0]  sMask;
  logic [63:0] sData;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [1:0] startMask(input logic [31:0] target);
    int firstLane;
`ifdef FETCH_UNALIGNED_EN
    firstLane = int'(target % 32'(STRIDE)) / (XLEN / 8);
`else
    firstLane = 0;
`endif
    return 2'(3 << firstLane);
  endfunction

  task automatic applyStimulus(input bit rst);
    reset       = rst;
    redirect    = kRedirect;
    redirect_pc = kRedirectPc;
    halt        = kHalt;
    imem_gnt    = ($urandom_range(99) < gntPct);
    dec_ready   = ($urandom_range(99) < readyPct);
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = {$urandom, $urandom};
    end
  endtask

  task automatic checkOutput();
    sReq = imem_req; sAddr = imem_addr; sValid = dec_valid;
    sPc = dec_pc; sMask = dec_mask; sData = dec_data;
    mReq = !reset && (mState == FETCH) && !redirect && (pend.size() + bq.size() < QDEPTH);
    if (started) begin
      checkEq("imem_req", sReq, mReq);
      if (mReq) checkEq("imem_addr", sAddr, mPc);
      checkEq("dec_valid", sValid, bq.size() > 0);
      if (bq.size() > 0) begin
        checkEq("dec_data", sData, bq[0].data);
        checkEq("dec_pc", sPc, bq[0].pc);
        checkEq("dec_mask", sMask, bq[0].mask);
      end
    end
  endtask

  task automatic modelUpdate();
    memReq_t e;
    if (reset) begin
      pend.delete(); bq.delete();
      mState = BOOT; mPc = RESET_PC; mMask = 2'b11; epoch++;
    end else begin
      if (bq.size() > 0 && dec_ready) void'(bq.pop_front());
      if (imem_rvalid) begin
        e = pend.pop_front();
        if (!redirect && e.epoch == epoch)
          bq.push_back('{mask: e.mask, pc: e.addr, data: e.data});
      end
      if (mReq && imem_gnt) begin
        pend.push_back('{addr: mPc, epoch: epoch, mask: mMask, data: {$urandom, $urandom},
                         due: cycle + int'($urandom_range(latMax, latMin))});
        mPc = mPc + 32'(STRIDE);
        mMask = 2'b11;
      end
      if (redirect) begin
        epoch++;
        bq.delete();
        mPc = redirect_pc & ~32'(STRIDE - 1);
        mMask = startMask(redirect_pc);
      end
      if (mState == BOOT) mState = FETCH;
      else if (mState == FETCH && halt && !redirect) mState = HALTED;
      else if (mState == HALTED && redirect) mState = FETCH;
    end
    cycle++;
  endtask

  task automatic cycleStep(input bit rst);
    @(negedge clk);
    applyStimulus(rst);
    #1;
    checkOutput();
    modelUpdate();
    kRedirect = 0;
  endtask

  task automatic doReset();
    kRedirect = 0; kHalt = 0;
    repeat (2) cycleStep(1);
    started = 1;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    do begin
      cycleStep(0);
      n++;
    end while (!sValid && n < 40);
    checkEq(name, sValid, 1'b1);
  endtask

  int count;

  initial begin
    // Straight-line streaming: requests every cycle, one-cycle memory latency.
    gntPct = 100; readyPct = 100; latMin = 1; latMax = 1;
    doReset();
    cycleStep(0);
    checkEq("rst_req", sReq, 1'b0);
    checkEq("rst_addr", sAddr, RESET_PC);
    checkEq("rst_valid", sValid, 1'b0);
    checkEq("rst_data", sData, 64'h0);
    checkEq("rst_pc", sPc, 32'h0);
    checkEq("rst_mask", sMask, 2'b00);
    cycleStep(0);
    checkEq("first_req", sReq, 1'b1);
    checkEq("first_addr", sAddr, 32'h0);
    cycleStep(0);
    checkEq("addr_8", sAddr, 32'h8);
    checkEq("valid_latency", sValid, 1'b0);
    cycleStep(0);
    checkEq("addr_16", sAddr, 32'h10);
    checkEq("first_dec_valid", sValid, 1'b1);
    checkEq("first_dec_pc", sPc, 32'h0);
    cycleStep(0);
    checkEq("second_dec_pc", sPc, 32'h8);
    checkEq("second_dec_mask", sMask, 2'b11);
    repeat (10) cycleStep(0);

    // Decoder stalled: exactly QDEPTH requests, then drain one per cycle.
    readyPct = 0;
    doReset();
    count = 0;
    repeat (12) begin
      cycleStep(0);
      if (sReq && imem_gnt) count++;
    end
    checkEq("stall_req_count", 64'(count), 64'(QDEPTH));
    checkEq("stall_req_low", sReq, 1'b0);
    checkEq("stall_head_pc", sPc, 32'h0);
    readyPct = 100;
    for (int i = 0; i < QDEPTH; i++) begin
      cycleStep(0);
      checkEq("drain_pc", sPc, 32'(i * STRIDE));
    end
    repeat (6) cycleStep(0);

    // Redirect with three requests outstanding.
    latMin = 5; latMax = 5;
    doReset();
    repeat (4) cycleStep(0);
    kRedirect = 1; kRedirectPc = 32'h100;
    cycleStep(0);
    checkEq("redir_cycle_req", sReq, 1'b0);
    cycleStep(0);
    checkEq("redir_req", sReq, 1'b1);
    checkEq("redir_addr", sAddr, 32'h100);
    waitValid("redir_valid_timeout");
    checkEq("redir_first_pc", sPc, 32'h100);
    repeat (8) cycleStep(0);

    // Halt drains in-flight bundles, redirect resumes fetching.
    latMin = 3; latMax = 3;
    doReset();
    repeat (3) cycleStep(0);
    kHalt = 1;
    cycleStep(0);
    count = 0;
    repeat (10) begin
      cycleStep(0);
      checkEq("halted_req", sReq, 1'b0);
      if (sValid && dec_ready) count++;
    end
    checkEq("halt_delivered", 64'(count), 64'd3);
    kHalt = 0; kRedirect = 1; kRedirectPc = 32'h40;
    cycleStep(0);
    cycleStep(0);
    checkEq("resume_req", sReq, 1'b1);
    checkEq("resume_addr", sAddr, 32'h40);
    repeat (6) cycleStep(0);

    // Unaligned redirect target.
    latMin = 1; latMax = 1;
    doReset();
    repeat (3) cycleStep(0);
    kRedirect = 1; kRedirectPc = 32'h104;
    cycleStep(0);
    cycleStep(0);
    checkEq("unal_addr", sAddr, 32'h100);
    waitValid("unal_valid_timeout");
    checkEq("unal_pc", sPc, 32'h100);
`ifdef FETCH_UNALIGNED_EN
    checkEq("unal_mask", sMask, 2'b10);
`else
    checkEq("unal_mask", sMask, 2'b11);
`endif
    cycleStep(0);
    checkEq("unal_next_pc", sPc, 32'h108);
    checkEq("unal_next_mask", sMask, 2'b11);

    // Address wrap, then reset in the middle of a stream.
    kRedirect = 1; kRedirectPc = 32'hFFFF_FFF8;
    cycleStep(0);
    cycleStep(0);
    checkEq("wrap_req", sReq, 1'b1);
    checkEq("wrap_addr_hi", sAddr, 32'hFFFF_FFF8);
    cycleStep(0);
    checkEq("wrap_addr_lo", sAddr, 32'h0);
    repeat (4) cycleStep(0);
    cycleStep(1);
    cycleStep(0);
    checkEq("midrst_valid", sValid, 1'b0);
    checkEq("midrst_req", sReq, 1'b0);
    cycleStep(0);
    checkEq("midrst_refetch_req", sReq, 1'b1);
    checkEq("midrst_refetch_addr", sAddr, RESET_PC);

    // Randomized traffic against the model.
    gntPct = 70; readyPct = 70; latMin = 1; latMax = 4;
    doReset();
    repeat (3000) begin
      kRedirect = ($urandom_range(99) < 3);
      kRedirectPc = $urandom;
      kHalt = ($urandom_range(99) < 2);
      cycleStep($urandom_range(999) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
